// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg: shared encodings for ID-stage branch hazard control.
package branch_hazard_ctrl_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {RESOLVE = 1'b0, STALL = 1'b1} state_t;
  // $0 is hardwired, so it can never be a real producer for the branch.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    return (dst != REG_ZERO) && ((dst == rs) || (dst == rt));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a freeze input.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         hold,
  output logic [W-1:0] cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else if (inc && !hold && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign cnt = r_cnt;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch stall, forward-select and flush sequencing.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Branch,
  input  logic             BranchNot,
  input  logic [4:0]       rsAddr,
  input  logic [4:0]       rtAddr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst_addr,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dst_addr,
  input  logic             cmp_equal,
  input  logic             hold_in,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic             branch_taken,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t     r_state, w_state_nxt;
  logic [1:0] r_stall_left, w_stall_left_nxt, w_need;
  logic       w_ex_hit, w_mem_load_hit, w_stall, w_resolve, w_mem_fwd;

  assign w_ex_hit       = ex_reg_write && reg_match(ex_dst_addr, rsAddr, rtAddr);
  assign w_mem_load_hit = mem_mem_read && reg_match(mem_dst_addr, rsAddr, rtAddr);
  assign w_need         = w_ex_hit ? (ex_mem_read ? 2'd2 : 2'd1) : (w_mem_load_hit ? 2'd1 : 2'd0);

  always_comb begin
    w_state_nxt      = r_state;
    w_stall_left_nxt = r_stall_left;
    w_stall          = 1'b0;
    if (r_state == STALL) begin
      w_stall          = 1'b1;
      w_stall_left_nxt = r_stall_left - 2'd1;
      w_state_nxt      = (r_stall_left == 2'd1) ? RESOLVE : STALL;
    end else if (Branch && w_need != 2'd0) begin
      w_stall          = 1'b1;
      w_stall_left_nxt = w_need - 2'd1;
      w_state_nxt      = (w_need == 2'd1) ? RESOLVE : STALL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RESOLVE;
      r_stall_left <= 2'd0;
    end else if (!hold_in) begin
      r_state      <= w_state_nxt;
      r_stall_left <= w_stall_left_nxt;
    end
  end

  // Outputs are gated by reset_n so they drop the moment reset asserts.
  assign w_resolve    = reset_n && r_state == RESOLVE && Branch && w_need == 2'd0;
  assign w_mem_fwd    = w_resolve && mem_reg_write && !mem_mem_read && mem_dst_addr != REG_ZERO;
  assign fwd_sel_a    = (w_mem_fwd && mem_dst_addr == rsAddr) ? FWD_EXMEM : FWD_REG;
  assign fwd_sel_b    = (w_mem_fwd && mem_dst_addr == rtAddr) ? FWD_EXMEM : FWD_REG;
  assign stall        = reset_n && w_stall;
  assign branch_taken = w_resolve && !hold_in && (cmp_equal ^ BranchNot);
  assign ifid_flush   = branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(stall), .hold(hold_in), .cnt(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk(clk), .reset_n(reset_n), .inc(branch_taken), .hold(hold_in), .cnt(taken_cnt)
  );
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed scenarios for branch_hazard_ctrl with inline checks.
module tb_branch_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, Branch, BranchNot, ex_reg_write, ex_mem_read;
  logic        mem_reg_write, mem_mem_read, cmp_equal, hold_in;
  logic [4:0]  rsAddr, rtAddr, ex_dst_addr, mem_dst_addr;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall, branch_taken, ifid_flush;
  logic [15:0] stall_cnt, taken_cnt;
  int          checks = 0;
  int          failures = 0;

  branch_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .Branch(Branch), .BranchNot(BranchNot),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dst_addr(ex_dst_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_dst_addr(mem_dst_addr), .cmp_equal(cmp_equal), .hold_in(hold_in),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall),
    .branch_taken(branch_taken), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle;
    Branch = 0; BranchNot = 0; rsAddr = 0; rtAddr = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_dst_addr = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_dst_addr = 0;
    cmp_equal = 0; hold_in = 0;
  endtask

  task automatic test_reset;
    reset_n = 0; idle;
    repeat (2) @(negedge clk);
    #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end checks++;
    if (branch_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", branch_taken); end checks++;
    if (ifid_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", ifid_flush); end checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_sel_a, fwd_sel_b); end checks++;
    if (stall_cnt !== 16'd0 || taken_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, taken_cnt); end checks++;
    @(negedge clk); reset_n = 1;
  endtask

  task automatic test_beq_no_hazard;
    @(negedge clk); idle; Branch = 1; rsAddr = 1; rtAddr = 2; cmp_equal = 1; #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL beq_stall got=%b exp=0", stall); end checks++;
    if (branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", branch_taken); end checks++;
    if (ifid_flush !== 1'b1) begin failures++; $display("FAIL beq_flush got=%b exp=1", ifid_flush); end checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL beq_fwd got=%b/%b exp=00/00", fwd_sel_a, fwd_sel_b); end checks++;
    @(negedge clk); idle; #1;
    if (taken_cnt !== 16'd1) begin failures++; $display("FAIL beq_taken_cnt got=%0d exp=1", taken_cnt); end checks++;
    if (branch_taken !== 1'b0) begin failures++; $display("FAIL idle_taken got=%b exp=0", branch_taken); end checks++;
  endtask

  task automatic test_load_stall;
    @(negedge clk); idle; Branch = 1; BranchNot = 1; rsAddr = 3; rtAddr = 4;
    ex_reg_write = 1; ex_mem_read = 1; ex_dst_addr = 3; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL load_stall1 got=%b exp=1", stall); end checks++;
    if (branch_taken !== 1'b0) begin failures++; $display("FAIL load_taken1 got=%b exp=0", branch_taken); end checks++;
    @(negedge clk); ex_reg_write = 0; ex_mem_read = 0; ex_dst_addr = 0;
    mem_reg_write = 1; mem_mem_read = 1; mem_dst_addr = 3; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL load_stall2 got=%b exp=1", stall); end checks++;
    if (fwd_sel_a !== 2'b00) begin failures++; $display("FAIL load_fwd_stall got=%b exp=00", fwd_sel_a); end checks++;
    @(negedge clk); mem_reg_write = 0; mem_mem_read = 0; mem_dst_addr = 0; cmp_equal = 0; #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL load_stall3 got=%b exp=0", stall); end checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL load_fwd got=%b/%b exp=00/00", fwd_sel_a, fwd_sel_b); end checks++;
    if (branch_taken !== 1'b1 || ifid_flush !== 1'b1) begin failures++; $display("FAIL load_bne_taken got=%b/%b exp=1/1", branch_taken, ifid_flush); end checks++;
    @(negedge clk); idle; #1;
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL load_stall_cnt got=%0d exp=2", stall_cnt); end checks++;
    if (taken_cnt !== 16'd2) begin failures++; $display("FAIL load_taken_cnt got=%0d exp=2", taken_cnt); end checks++;
  endtask

  task automatic test_alu_fwd;
    @(negedge clk); idle; Branch = 1; rsAddr = 5; rtAddr = 6; ex_reg_write = 1; ex_dst_addr = 5; cmp_equal = 1; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL alu_stall got=%b exp=1", stall); end checks++;
    @(negedge clk); ex_reg_write = 0; ex_dst_addr = 0; mem_reg_write = 1; mem_dst_addr = 5; #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall_done got=%b exp=0", stall); end checks++;
    if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL alu_fwd_a got=%b/%b exp=01/00", fwd_sel_a, fwd_sel_b); end checks++;
    if (branch_taken !== 1'b1) begin failures++; $display("FAIL alu_taken got=%b exp=1", branch_taken); end checks++;
    @(negedge clk); idle; Branch = 1; rsAddr = 6; rtAddr = 5; mem_reg_write = 1; mem_dst_addr = 5; #1;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b01) begin failures++; $display("FAIL alu_fwd_b got=%b/%b exp=00/01", fwd_sel_a, fwd_sel_b); end checks++;
    if (branch_taken !== 1'b0) begin failures++; $display("FAIL alu_not_taken got=%b exp=0", branch_taken); end checks++;
    @(negedge clk); idle; #1;
    if (stall_cnt !== 16'd3 || taken_cnt !== 16'd3) begin failures++; $display("FAIL alu_cnt got=%0d/%0d exp=3/3", stall_cnt, taken_cnt); end checks++;
  endtask

  task automatic test_zero_reg;
    @(negedge clk); idle; Branch = 1; ex_reg_write = 1; ex_mem_read = 1;
    mem_reg_write = 1; mem_mem_read = 0; cmp_equal = 1; #1;
    if (stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", stall); end checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL zero_fwd got=%b/%b exp=00/00", fwd_sel_a, fwd_sel_b); end checks++;
    if (branch_taken !== 1'b1) begin failures++; $display("FAIL zero_taken got=%b exp=1", branch_taken); end checks++;
    @(negedge clk); idle; Branch = 1; BranchNot = 1; rsAddr = 8; rtAddr = 9; cmp_equal = 1; #1;
    if (branch_taken !== 1'b0 || ifid_flush !== 1'b0) begin failures++; $display("FAIL bne_equal got=%b/%b exp=0/0", branch_taken, ifid_flush); end checks++;
    @(negedge clk); idle; #1;
    if (taken_cnt !== 16'd4) begin failures++; $display("FAIL zero_taken_cnt got=%0d exp=4", taken_cnt); end checks++;
  endtask

  task automatic test_hold_resolve;
    @(negedge clk); idle; Branch = 1; rsAddr = 1; rtAddr = 2; cmp_equal = 1; hold_in = 1; #1;
    if (branch_taken !== 1'b0 || ifid_flush !== 1'b0) begin failures++; $display("FAIL hold_taken got=%b/%b exp=0/0", branch_taken, ifid_flush); end checks++;
    @(negedge clk); hold_in = 0; #1;
    if (branch_taken !== 1'b1) begin failures++; $display("FAIL hold_release_taken got=%b exp=1", branch_taken); end checks++;
    @(negedge clk); idle; #1;
    if (taken_cnt !== 16'd5) begin failures++; $display("FAIL hold_taken_cnt got=%0d exp=5", taken_cnt); end checks++;
  endtask

  task automatic test_hold_stall;
    @(negedge clk); idle; Branch = 1; rsAddr = 7; rtAddr = 1; ex_reg_write = 1; ex_mem_read = 1; ex_dst_addr = 7; cmp_equal = 1; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL hstall_first got=%b exp=1", stall); end checks++;
    @(negedge clk); ex_reg_write = 0; ex_mem_read = 0; ex_dst_addr = 0;
    mem_reg_write = 1; mem_mem_read = 1; mem_dst_addr = 7; hold_in = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall !== 1'b1) begin failures++; $display("FAIL hstall_held%0d got=%b exp=1", i, stall); end checks++;
      if (branch_taken !== 1'b0) begin failures++; $display("FAIL hstall_taken%0d got=%b exp=0", i, branch_taken); end checks++;
      if (stall_cnt !== 16'd4) begin failures++; $display("FAIL hstall_cnt%0d got=%0d exp=4", i, stall_cnt); end checks++;
      @(negedge clk);
    end
    hold_in = 0; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL hstall_after got=%b exp=1", stall); end checks++;
    @(negedge clk); mem_reg_write = 0; mem_mem_read = 0; mem_dst_addr = 0; #1;
    if (stall !== 1'b0 || branch_taken !== 1'b1) begin failures++; $display("FAIL hstall_resolve got=%b/%b exp=0/1", stall, branch_taken); end checks++;
    @(negedge clk); idle; #1;
    if (stall_cnt !== 16'd5 || taken_cnt !== 16'd6) begin failures++; $display("FAIL hstall_cnts got=%0d/%0d exp=5/6", stall_cnt, taken_cnt); end checks++;
  endtask

  task automatic test_branch_drop;
    @(negedge clk); idle; Branch = 1; rsAddr = 3; ex_reg_write = 1; ex_mem_read = 1; ex_dst_addr = 3; #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL drop_stall1 got=%b exp=1", stall); end checks++;
    @(negedge clk); idle; cmp_equal = 1; #1;
    if (stall !== 1'b1 || branch_taken !== 1'b0) begin failures++; $display("FAIL drop_countdown got=%b/%b exp=1/0", stall, branch_taken); end checks++;
    @(negedge clk); #1;
    if (stall !== 1'b0 || branch_taken !== 1'b0) begin failures++; $display("FAIL drop_done got=%b/%b exp=0/0", stall, branch_taken); end checks++;
    if (stall_cnt !== 16'd7 || taken_cnt !== 16'd6) begin failures++; $display("FAIL drop_cnts got=%0d/%0d exp=7/6", stall_cnt, taken_cnt); end checks++;
  endtask

  task automatic test_reset_in_stall;
    @(negedge clk); idle; Branch = 1; rsAddr = 3; ex_reg_write = 1; ex_mem_read = 1; ex_dst_addr = 3; #1;
    @(negedge clk); #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall got=%b exp=1", stall); end checks++;
    reset_n = 0; #1;
    if (stall !== 1'b0 || branch_taken !== 1'b0 || ifid_flush !== 1'b0) begin failures++; $display("FAIL rst_outputs got=%b/%b/%b exp=0/0/0", stall, branch_taken, ifid_flush); end checks++;
    if (stall_cnt !== 16'd0 || taken_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", stall_cnt, taken_cnt); end checks++;
    @(negedge clk); reset_n = 1; idle; Branch = 1; rsAddr = 1; rtAddr = 2; cmp_equal = 1; #1;
    if (stall !== 1'b0 || branch_taken !== 1'b1) begin failures++; $display("FAIL rst_resolve got=%b/%b exp=0/1", stall, branch_taken); end checks++;
    @(negedge clk); idle; #1;
    if (stall_cnt !== 16'd0 || taken_cnt !== 16'd1) begin failures++; $display("FAIL rst_post_cnts got=%0d/%0d exp=0/1", stall_cnt, taken_cnt); end checks++;
  endtask

  initial begin
    test_reset;
    test_beq_no_hazard;
    test_load_stall;
    test_alu_fwd;
    test_zero_reg;
    test_hold_resolve;
    test_hold_stall;
    test_branch_drop;
    test_reset_in_stall;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences ID-stage branch resolution for the 5-stage MIPS pipeline.
- Decides when the ID-stage equality comparator may consume operands.
- Drives the operand-forward selects for that comparator.
- Inserts stall cycles for EX/MEM producers that are not yet available.
- Issues the IF/ID flush on a taken branch.
- Keeps saturating stall and taken-branch counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall and taken counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Branch  in  1  a valid BEQ/BNE is in ID.
- BranchNot  in  1  the instruction in ID is BNE.
- rsAddr  in  5  rs of the branch in ID.
- rtAddr  in  5  rt of the branch in ID.
- ex_reg_write  in  1  the ID/EX instruction writes the regfile.
- ex_mem_read  in  1  the ID/EX instruction is a load.
- ex_dst_addr  in  5  destination register of the ID/EX instruction.
- mem_reg_write  in  1  the EX/MEM instruction writes the regfile.
- mem_mem_read  in  1  the EX/MEM instruction is a load.
- mem_dst_addr  in  5  destination register of the EX/MEM instruction.
- cmp_equal  in  1  comparator result: selected A equals selected B.
- hold_in  in  1  external freeze (memory wait).
- fwd_sel_a  out  2  comparator A source: 00 regfile, 01 EX/MEM aluOut.
- fwd_sel_b  out  2  comparator B source, same encoding.
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX.
- branch_taken  out  1  select the branch target for the PC.
- ifid_flush  out  1  squash the fetched instruction in IF/ID.
- stall_cnt  out  CNT_W  cycles in which stall was asserted.
- taken_cnt  out  CNT_W  number of taken branches.

Behaviour:
- Reset (asynchronous, reset_n=0): state=RESOLVE, stall_left=0, both counters=0. All outputs 0; fwd_sel_a and fwd_sel_b are 00.
- A register "matches" only if it is nonzero and equals rsAddr or rtAddr. $0 never causes a hazard or a forward.
- Needed stalls N, evaluated only in RESOLVE with Branch=1:
  - ex_reg_write and ex_dst match, load: N=2.
  - ex_reg_write and ex_dst match, non-load: N=1.
  - Otherwise, mem_mem_read and mem_dst match: N=1.
  - Otherwise: N=0.
- The regfile writes in the first half-cycle, so WB-stage producers never need forwarding.
- FSM states: RESOLVE, STALL.
  - RESOLVE with Branch=1 and N>0: stall=1 combinationally in that cycle; stall_left<=N-1. Next state is STALL if N-1>0, else RESOLVE.
  - STALL: stall=1. Decrement stall_left; return to RESOLVE when it reaches 0. RESOLVE then re-evaluates, and the hazard must now be clear.
- Forwarding, in RESOLVE with N=0: fwd_sel_x=01 when mem_reg_write, not mem_mem_read, and mem_dst_addr equals that operand (nonzero). Otherwise 00. In STALL both selects are 00.
- Outcome, in RESOLVE with N=0 and Branch=1:
  - branch_taken = cmp_equal XOR BranchNot.
  - ifid_flush = branch_taken, combinational in the same cycle.
  - Zero latency from operand availability.
- hold_in=1 has priority over everything:
  - FSM, stall_left and counters are frozen.
  - stall keeps its current value.
  - branch_taken and ifid_flush are forced to 0.
  - The branch resolves in the first cycle after hold_in drops, using the then-current inputs.
- Counters: stall_cnt increments on every cycle with stall=1 and hold_in=0. taken_cnt increments on every cycle with branch_taken=1. Both saturate at all-ones with no wrap.
- If Branch drops while in STALL (upstream kill), the FSM still completes its countdown; no outcome is issued.
- Non-branch cycles in RESOLVE: stall, branch_taken and ifid_flush are 0 and fwd_sel is 00.

Decomposition:
- Shared pipeline package holds:
  - FWD_REG=2'b00 and FWD_EXMEM=2'b01.
  - The state encoding RESOLVE/STALL.
  - REG_ZERO=5'd0.
- One natural sub-module: sat_counter (parameterised width; inc and hold inputs), instantiated twice.
- Hazard classification and the FSM live in the top module.

Test Plan:
- BEQ $1,$2 with no producers and cmp_equal=1: same cycle gives stall=0, branch_taken=1, ifid_flush=1; taken_cnt goes 0→1.
- lw $3 in EX, BNE $3,$4: stall=1 for exactly 2 cycles (stall_cnt=2). Then with the load in WB, resolution gives fwd 00/00; cmp_equal=0 → taken=1.
- add $5 in EX, BEQ $5,$6: 1 stall cycle. Next cycle, add in MEM with mem_reg_write: fwd_sel_a=01, fwd_sel_b=00, and resolution happens.
- add $0 in EX, BEQ $0,$0: no stall, fwd 00/00, taken=1.
- hold_in=1 for 3 cycles during a 2-cycle load stall: stall stays 1 throughout and stall_cnt excludes held cycles. Total stall cycles counted = 2; branch_taken=0 while held.
- reset_n pulsed low in STALL: stall, outputs and counters go to 0 immediately. After release the FSM is in RESOLVE.
